// File: rtl/mcp3008_pkg.sv
// Shared types, frame constants and channel-selection helpers for the MCP3008 scanner.
package mcp3008_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    STORE,
    GAP
  } scan_state_t;

  localparam int FRAME_LEN  = 17;
  localparam int DATA_START = 8;

  // Lowest set mask bit at or above ptr, searching upward and wrapping 7 -> 0.
  function automatic logic [2:0] pick_channel(input logic [7:0] mask, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    pick_channel = ptr;
    found        = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && mask[idx]) begin
        pick_channel = idx;
        found        = 1'b1;
      end
    end
  endfunction

  function automatic logic none_above(input logic [7:0] mask, input logic [2:0] ch);
    none_above = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > int'(ch) && mask[i]) none_above = 1'b0;
    end
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// SCLK half-period timer; tick marks the last clk of each half, rise/fall qualify it during SHIFT.
module sclk_tick_gen #(
  parameter int HALF_DIV = 675
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic shift,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam logic [11:0] HALF_LAST = 12'(HALF_DIV - 1);

  logic [11:0] cnt;
  logic        phase;

  assign tick = run && (cnt == HALF_LAST);
  assign rise = tick && shift && !phase;
  assign fall = tick && shift && phase;
  assign sclk = phase;

  // The counter restarts on every tick, so each state that runs it begins at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 12'd0;
      phase <= 1'b0;
    end else begin
      if (!run || tick) cnt <= 12'd0;
      else              cnt <= cnt + 12'd1;
      if (!shift)    phase <= 1'b0;
      else if (tick) phase <= ~phase;
    end
  end

endmodule

// File: rtl/mcp3008_scanner.sv
// MCP3008 round-robin scanner: one 17-clock SPI frame per enabled channel,
// publishing each 10-bit result with its channel number.
module mcp3008_scanner
  import mcp3008_pkg::*;
#(
  parameter int HALF_DIV = 675,
  parameter int CS_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] chan_mask,
  output logic       AD_CLK,
  output logic       CS,
  output logic       DIN,
  input  logic       DOUT,
  output logic [9:0] sample_data,
  output logic [2:0] sample_ch,
  output logic       sample_valid,
  output logic       scan_done
);

  // The gap is counted in half-periods so the 16-bit counter cannot overflow at any legal setting.
  localparam logic [15:0] GAP_LAST = 16'(2 * CS_GAP - 1);

  scan_state_t state, state_next;
  logic        tick, rise, fall, sclk;
  logic        run_tick, in_shift;
  logic        can_start, load, store_go;
  logic [2:0]  sel_ch, ptr, ch_q;
  logic [7:0]  mask_q;
  logic [4:0]  cmd_sr, rise_cnt;
  logic [9:0]  data_sr;
  logic [15:0] gap_cnt;
  logic        cs_q;

  assign run_tick  = (state == SETUP) || (state == SHIFT) || (state == GAP);
  assign in_shift  = (state == SHIFT);
  assign can_start = enable && (chan_mask != 8'd0);
  assign sel_ch    = pick_channel(chan_mask, ptr);

  assign AD_CLK = sclk;
  assign CS     = cs_q;
  assign DIN    = cmd_sr[4];

  sclk_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_tick),
    .shift (in_shift),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall),
    .sclk  (sclk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The frame ends on the falling edge of the 17th SCLK period, never on enable.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    store_go   = 1'b0;
    case (state)
      IDLE: begin
        if (can_start) begin
          state_next = SETUP;
          load       = 1'b1;
        end
      end
      SETUP: if (tick) state_next = SHIFT;
      SHIFT: begin
        if (fall && rise_cnt == 5'(FRAME_LEN)) begin
          state_next = STORE;
          store_go   = 1'b1;
        end
      end
      STORE: state_next = GAP;
      GAP: begin
        if (tick && gap_cnt == GAP_LAST) begin
          if (can_start) begin
            state_next = SETUP;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The mask is captured with the channel so later edits only affect the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q         <= 1'b1;
      cmd_sr       <= 5'd0;
      rise_cnt     <= 5'd0;
      data_sr      <= 10'd0;
      gap_cnt      <= 16'd0;
      ptr          <= 3'd0;
      ch_q         <= 3'd0;
      mask_q       <= 8'd0;
      sample_data  <= 10'd0;
      sample_ch    <= 3'd0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      cs_q         <= !((state_next == SETUP) || (state_next == SHIFT));
      sample_valid <= store_go;
      scan_done    <= store_go && none_above(mask_q, ch_q);

      if (state == GAP) begin
        if (tick) gap_cnt <= gap_cnt + 16'd1;
      end else begin
        gap_cnt <= 16'd0;
      end

      if (load) begin
        ch_q     <= sel_ch;
        mask_q   <= chan_mask;
        cmd_sr   <= {2'b11, sel_ch};
        rise_cnt <= 5'd0;
        data_sr  <= 10'd0;
      end else begin
        if (rise) begin
          rise_cnt <= rise_cnt + 5'd1;
          if (rise_cnt >= 5'(DATA_START - 1)) data_sr <= {data_sr[8:0], DOUT};
        end
        if (fall) cmd_sr <= {cmd_sr[3:0], 1'b0};
      end

      if (store_go) begin
        sample_data <= data_sr;
        sample_ch   <= ch_q;
        ptr         <= ch_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_scanner.sv
// Bench for mcp3008_scanner: behavioural MCP3008 on the SPI pins, table-driven scan orders,
// hand-built corner sequences and a randomized run against a reference scan model.
module tb_mcp3008_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] chan_mask = 8'd0;
  logic       DOUT = 1'b0;
  logic       AD_CLK, CS, DIN;
  logic [9:0] sample_data;
  logic [2:0] sample_ch;
  logic       sample_valid, scan_done;

  mcp3008_scanner #(.HALF_DIV(2), .CS_GAP(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .chan_mask    (chan_mask),
    .AD_CLK       (AD_CLK),
    .CS           (CS),
    .DIN          (DIN),
    .DOUT         (DOUT),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .scan_done    (scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ch;
    logic [9:0] data;
    logic       done;
    int         cs_len;
    int         gap;
    logic [4:0] cmd;
    logic       tail_err;
    logic [7:0] mask;
  } obs_t;

  typedef struct {
    logic [7:0]  mask;
    logic [11:0] chs;
    logic [3:0]  done;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  obs_t       obs_q[$];
  logic [9:0] chan_val[8];

  logic       mon_on = 1'b0;
  logic       prev_cs = 1'b1;
  logic       prev_ad = 1'b0;
  int         rise_n = 0, fall_n = 0, cs_len = 0, gap_len = 0, frame_gap = 0;
  int         idle_viol = 0, stray_done = 0;
  logic [4:0] cmd = 5'd0;
  logic       tail_err = 1'b0;
  logic [7:0] sel_mask = 8'd0;
  logic [9:0] mv;
  logic       rand_done = 1'b0;

  // Behavioural MCP3008 plus frame observer: decodes the command from DIN on SCLK rises and
  // shifts the channel's value out after falls 7..16 so bit 9 is valid at rise 8.
  always @(negedge clk) begin
    if (mon_on) begin
      if (CS) begin
        if (!prev_cs) gap_len = 0;
        gap_len++;
        rise_n = 0;
        fall_n = 0;
        DOUT   = 1'b0;
      end else begin
        if (prev_cs) begin
          cs_len    = 0;
          cmd       = 5'd0;
          tail_err  = 1'b0;
          sel_mask  = chan_mask;
          frame_gap = gap_len;
        end
        cs_len++;
        if (AD_CLK && !prev_ad) begin
          rise_n++;
          if (rise_n <= 5) cmd = {cmd[3:0], DIN};
          else if (DIN !== 1'b0) tail_err = 1'b1;
        end
        if (!AD_CLK && prev_ad) begin
          fall_n++;
          if (fall_n >= 7 && fall_n <= 16) begin
            mv   = chan_val[cmd[2:0]];
            DOUT = mv[16 - fall_n];
          end else begin
            DOUT = 1'($urandom);
          end
        end
      end
      if (sample_valid === 1'b1)
        obs_q.push_back('{sample_ch, sample_data, scan_done, cs_len, frame_gap, cmd, tail_err, sel_mask});
      if (scan_done === 1'b1 && sample_valid !== 1'b1) stray_done++;
      if (CS === 1'b1 && (AD_CLK !== 1'b0 || DIN !== 1'b0)) idle_viol++;
      prev_cs = CS;
      prev_ad = AD_CLK;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] mask);
    @(negedge clk);
    enable    = en;
    chan_mask = mask;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n     = 1'b0;
    enable    = 1'b0;
    chan_mask = 8'd0;
    repeat (3) @(negedge clk);
    obs_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    int cyc = 0;
    while (obs_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (obs_q.size() < n) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: %0d samples seen, %0d required", name, obs_q.size(), n);
    end
  endtask

  task automatic wait_rise(input int n, input string name);
    int cyc = 0;
    while (!(rise_n == n && CS === 1'b0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout waiting for SCLK rise %0d", name, n);
    end
  endtask

  task automatic check_frame(input string name, input logic [2:0] ch, input logic [9:0] data,
                             input logic done, input bit chk_gap);
    obs_t o;
    wait_obs(1, 400, name);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checkOutput({name, "_ch"}, 32'(o.ch), 32'(ch));
      checkOutput({name, "_data"}, 32'(o.data), 32'(data));
      checkOutput({name, "_done"}, 32'(o.done), 32'(done));
      checkOutput({name, "_cmd"}, 32'(o.cmd), 32'({2'b11, ch}));
      checkOutput({name, "_cslow"}, 32'(o.cs_len), 32'd70);
      checkOutput({name, "_dintail"}, 32'(o.tail_err), 32'd0);
      if (chk_gap) checkOutput({name, "_cshigh"}, 32'(o.gap), 32'd5);
    end
  endtask

  function automatic logic [2:0] ref_pick(input logic [7:0] m, input logic [2:0] p);
    int set_q[$];
    for (int c = 0; c < 8; c++) if (m[c]) set_q.push_back(c);
    if (set_q.size() == 0) return 3'd0;
    foreach (set_q[i]) if (set_q[i] >= int'(p)) return 3'(set_q[i]);
    return 3'(set_q[0]);
  endfunction

  function automatic logic ref_last(input logic [7:0] m, input logic [2:0] c);
    int top = -1;
    for (int i = 0; i < 8; i++) if (m[i]) top = i;
    return top == int'(c);
  endfunction

  initial begin
    vec_t       vec_tbl[6];
    obs_t       o;
    int         cnt_a, cnt_b, cnt_c;
    logic [2:0] ref_ptr, exp_ch;

    vec_tbl[0] = '{8'h01, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b1111};
    vec_tbl[1] = '{8'hA4, {3'd2, 3'd5, 3'd7, 3'd2}, 4'b0010};
    vec_tbl[2] = '{8'h80, {3'd7, 3'd7, 3'd7, 3'd7}, 4'b1111};
    vec_tbl[3] = '{8'h81, {3'd0, 3'd7, 3'd0, 3'd7}, 4'b0101};
    vec_tbl[4] = '{8'hFF, {3'd0, 3'd1, 3'd2, 3'd3}, 4'b0000};
    vec_tbl[5] = '{8'h18, {3'd3, 3'd4, 3'd3, 3'd4}, 4'b0101};
    for (int i = 0; i < 8; i++) chan_val[i] = 10'(i * 100);

    $display("[TB] reset state");
    rst_n     = 1'b0;
    enable    = 1'b1;
    chan_mask = 8'hFF;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs", 32'(CS), 32'd1);
    checkOutput("rst_adclk", 32'(AD_CLK), 32'd0);
    checkOutput("rst_din", 32'(DIN), 32'd0);
    checkOutput("rst_data", 32'(sample_data), 32'd0);
    checkOutput("rst_ch", 32'(sample_ch), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_done", 32'(scan_done), 32'd0);
    mon_on = 1'b1;

    $display("[TB] single channel, fixed value");
    reset_dut();
    chan_val[0] = 10'h2A5;
    applyStimulus(1'b1, 8'h01);
    check_frame("single", 3'd0, 10'h2A5, 1'b1, 1'b0);
    chan_val[0] = 10'd0;

    $display("[TB] scan order table");
    for (int v = 0; v < 6; v++) begin
      reset_dut();
      applyStimulus(1'b1, vec_tbl[v].mask);
      for (int k = 0; k < 4; k++) begin
        exp_ch = vec_tbl[v].chs[11 - 3 * k -: 3];
        check_frame($sformatf("tbl%0d_f%0d", v, k), exp_ch, 10'(100 * int'(exp_ch)),
                    vec_tbl[v].done[3 - k], k > 0);
      end
    end

    $display("[TB] enable drop mid-frame");
    reset_dut();
    applyStimulus(1'b1, 8'h10);
    wait_rise(10, "endrop");
    enable = 1'b0;
    check_frame("endrop", 3'd4, 10'd400, 1'b1, 1'b0);
    cnt_a = 0;
    repeat (300) begin
      @(negedge clk);
      if (CS !== 1'b1) cnt_a++;
    end
    checkOutput("endrop_cslow_after", 32'(cnt_a), 32'd0);
    checkOutput("endrop_extra_samples", 32'(obs_q.size()), 32'd0);

    $display("[TB] reset mid-frame");
    reset_dut();
    chan_val[0] = 10'h155;
    applyStimulus(1'b1, 8'h21);
    check_frame("rstmid_pre", 3'd0, 10'h155, 1'b0, 1'b0);
    wait_rise(12, "rstmid");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_cs", 32'(CS), 32'd1);
    checkOutput("rstmid_adclk", 32'(AD_CLK), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstmid_nosample", 32'(obs_q.size()), 32'd0);
    check_frame("rstmid_post", 3'd0, 10'h155, 1'b0, 1'b0);
    chan_val[0] = 10'd0;

    $display("[TB] empty mask");
    reset_dut();
    applyStimulus(1'b1, 8'h00);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    repeat (1000) begin
      @(negedge clk);
      if (CS !== 1'b1) cnt_a++;
      if (AD_CLK !== 1'b0) cnt_b++;
      if (sample_valid !== 1'b0 || scan_done !== 1'b0) cnt_c++;
    end
    checkOutput("nomask_cslow", 32'(cnt_a), 32'd0);
    checkOutput("nomask_adclk", 32'(cnt_b), 32'd0);
    checkOutput("nomask_strobes", 32'(cnt_c), 32'd0);

    $display("[TB] randomized scan with mid-frame mask changes");
    reset_dut();
    for (int i = 0; i < 8; i++) chan_val[i] = 10'($urandom);
    applyStimulus(1'b1, 8'($urandom_range(1, 255)));
    ref_ptr   = 3'd0;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          wait_obs(1, 400, "rand");
          if (obs_q.size() > 0) begin
            o      = obs_q.pop_front();
            exp_ch = ref_pick(o.mask, ref_ptr);
            checkOutput($sformatf("rand%0d_ch", n), 32'(o.ch), 32'(exp_ch));
            checkOutput($sformatf("rand%0d_data", n), 32'(o.data), 32'(chan_val[exp_ch]));
            checkOutput($sformatf("rand%0d_done", n), 32'(o.done), 32'(ref_last(o.mask, exp_ch)));
            ref_ptr = exp_ch + 3'd1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          while (CS === 1'b1 && !rand_done) @(negedge clk);
          repeat ($urandom_range(1, 50)) @(negedge clk);
          chan_mask = 8'($urandom_range(1, 255));
          while (CS === 1'b0 && !rand_done) @(negedge clk);
        end
      end
    join

    checkOutput("idle_lines_quiet", 32'(idle_viol), 32'd0);
    checkOutput("stray_scan_done", 32'(stray_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mcp3008_scanner.md
MCP3008_SCANNER -- requirements
Module: mcp3008_scanner

Interface
REQ-001 SHALL have parameter HALF_DIV, default 675: clk cycles per SCLK half-period, legal range 2..4095.
REQ-002 SHALL have parameter CS_GAP, default 2: whole SCLK periods with CS high between frames, legal range 1..15.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 enable  input  1  scanning permitted while high.
REQ-007 chan_mask  input  8  bit n set = channel n is scanned.
REQ-008 AD_CLK  output  1  SPI SCLK to MCP3008.
REQ-009 CS  output  1  MCP3008 chip select, active-low.
REQ-010 DIN  output  1  command bits to MCP3008.
REQ-011 DOUT  input  1  conversion bits from MCP3008.
REQ-012 sample_data  output  10  last conversion result.
REQ-013 sample_ch  output  3  channel of sample_data.
REQ-014 sample_valid  output  1  one-cycle strobe; sample_data and sample_ch are new this cycle.
REQ-015 scan_done  output  1  one-cycle strobe after the last enabled channel of a pass.

Function
REQ-016 SHALL implement states IDLE, SETUP, SHIFT, STORE, GAP.
REQ-017 IDLE: CS=1, AD_CLK=0, DIN=0; go to SETUP when enable=1 and chan_mask!=0, selecting the lowest set mask bit at or above the round-robin pointer, wrapping 7->0.
REQ-018 SETUP: CS=0, DIN=start bit 1, AD_CLK=0 for one half-period; then SHIFT.
REQ-019 SHIFT: 17 SCLK periods, each being low half-period then high half-period; AD_CLK rises at the end of each low half and falls at the end of each high half.
REQ-020 DIN SHALL change only on AD_CLK falling edges (or in SETUP), presenting in order 1, 1 (SGL), D2, D1, D0 on periods 1-5, then 0 for periods 6-17.
REQ-021 DOUT SHALL be sampled on the clk cycle of AD_CLK rising edges 8..17, MSB first, into a 10-bit shift register; edges 1-7 are ignored.
REQ-022 STORE: one clk cycle with CS=1, AD_CLK=0; sample_data/sample_ch update and sample_valid=1 in this cycle; the pointer advances to channel+1 mod 8.
REQ-023 scan_done SHALL pulse in the STORE cycle when no set mask bit lies above the stored channel.
REQ-024 GAP: CS=1 for CS_GAP*2*HALF_DIV clk cycles; then SETUP if enable=1 and chan_mask!=0, else IDLE.
REQ-025 Frame length SHALL be exactly HALF_DIV*(1+34) clk cycles from CS falling to STORE.
REQ-026 chan_mask SHALL be sampled only at channel selection; changes mid-frame affect the next frame only.
REQ-027 enable falling mid-frame SHALL NOT abort the frame; the frame completes, sample_valid fires, and the block then enters IDLE via GAP.
REQ-028 chan_mask==0 with enable=1 SHALL hold IDLE with CS=1 indefinitely.
REQ-029 Half-period and gap counters SHALL be 12-bit and 16-bit respectively; a counter SHALL never wrap within a state.

Reset
REQ-030 rst_n=0 SHALL force, on the next clk edge, state=IDLE, CS=1, AD_CLK=0, DIN=0, sample_data=0, sample_ch=0, sample_valid=0, scan_done=0, pointer=0, and all counters=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no sample_valid; CS SHALL rise on that edge.

Structure
REQ-032 State enum, frame length constant (17) and data-start edge constant (8) SHALL live in package mcp3008_pkg.
REQ-033 SCLK half-period timing SHALL be a sub-module sclk_tick_gen that produces rise/fall tick strobes; everything else SHALL be in one module.

Verification
REQ-034 HALF_DIV=2, mask=8'h01, enable=1, DOUT model returns 10'h2A5 -> DIN bits 1,1,0,0,0; sample_valid with data=10'h2A5, ch=0; scan_done in the same cycle.
REQ-035 mask=8'hA4, model returns channel*100 -> samples in order ch2=200, ch5=500, ch7=700, scan_done after ch7, next pass restarts at ch2.
REQ-036 HALF_DIV=2, CS_GAP=1 -> CS low exactly 70 cycles per frame; CS high for 1 (STORE) + 4 (GAP) cycles between frames.
REQ-037 enable dropped at SCLK edge 10 -> the frame completes with a correct value, then CS stays high and no further frames start.
REQ-038 rst_n asserted at SCLK edge 12 -> CS=1 next cycle, no sample_valid; after release the first frame is ch0 with the correct value.
REQ-039 mask=0, enable=1 for 1000 cycles -> CS=1, AD_CLK=0 throughout; no strobes.
